game_clock_scoreboard: RTL
==========================

Name: game_clock_scoreboard

Overview:
- Parametrised successor of the basketball score/timer controller.
- Contains a multi-period countdown game clock and an N-team saturating BCD score bank with add and correct operations, all run by a game state machine.
- Emits packed BCD digits and status to the downstream 7-segment display multiplexer. There are no binary divide/modulo operations on the display path.
- Single clock domain. All control inputs are synchronous one-cycle pulses, debounced and edge-detected upstream.

Parameters:
- TICK_CYCLES, 100000000, clock cycles per game-clock second (>=2).
- PERIOD_MIN, 12, period length in minutes (1..99), loaded as PERIOD_MIN:00.
- NUM_PERIODS, 4, periods per game (1..15).
- NUM_TEAMS, 2, number of score channels (2..8).
- SCORE_DIGITS, 3, BCD digits per score; max score is 10^SCORE_DIGITS-1.
- BUZZ_CYCLES, 50000000, buzzer pulse length in cycles (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear_game  in  1  sync pulse: return to IDLE and reload everything
- start_stop  in  1  pulse: start/pause/resume/advance period
- pts_valid  in  1  pulse: apply score operation
- pts  in  2  1,2,3 = add that many points; 0 = subtract 1 (correction)
- team_sel  in  3  target team index
- min_bcd  out  8  minutes, two BCD digits
- sec_bcd  out  8  seconds, two BCD digits
- period  out  4  current period, binary, starts at 1
- score_bcd  out  NUM_TEAMS*4*SCORE_DIGITS  team t occupies slice [t*4*SCORE_DIGITS +: 4*SCORE_DIGITS]
- state  out  3  IDLE=0, RUNNING=1, PAUSED=2, PERIOD_END=3, GAME_OVER=4
- buzzer  out  1  high for BUZZ_CYCLES cycles at end of period

Behaviour:
- Reset (async, active-low) and clear_game (sync, highest priority) produce identical state:
  - state=IDLE, min_bcd=PERIOD_MIN in BCD, sec_bcd=00, period=1;
  - all scores 0, buzzer=0, tick counter 0.
- Tick counter:
  - increments only in RUNNING;
  - at TICK_CYCLES-1 it wraps to 0 and generates a one-cycle internal tick;
  - it holds its value (no clear) in PAUSED, so resume keeps the fractional second.
- On tick, the clock decrements by 1 s in BCD:
  - sec units borrow from sec tens;
  - sec 00 -> 59 with a minute decrement;
  - minute units borrow from minute tens.
- State machine transitions:
  - IDLE + start_stop -> RUNNING.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING.
  - RUNNING + tick that makes the clock 00:00 -> PERIOD_END if period<NUM_PERIODS, else GAME_OVER. In both cases buzzer rises the next cycle and stays high exactly BUZZ_CYCLES cycles.
  - PERIOD_END + start_stop -> PAUSED, period+1, clock reloaded to PERIOD_MIN:00, tick counter 0. The buzzer finishes its count undisturbed.
  - GAME_OVER: start_stop ignored. Only clear_game or reset leaves it.
- Simultaneous tick and start_stop in RUNNING: the tick is applied first. If it reaches 00:00, the end-of-period transition wins and start_stop is dropped; otherwise the new state is PAUSED with the decremented time.
- The clock never wraps below 00:00. There is no modulo-12 restart.
- Scores:
  - pts_valid is accepted in RUNNING, PAUSED and PERIOD_END; ignored in IDLE and GAME_OVER.
  - pts_valid is ignored if team_sel>=NUM_TEAMS.
  - Updates are visible on score_bcd the cycle after pts_valid.
  - Addition is BCD with digit carry chain and saturates at all-9s (no wrap to 0).
  - pts=0 subtracts 1 and saturates at 0.
  - Score updates are independent of clock activity; a simultaneous tick and pts_valid both take effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
(Bench overrides: TICK_CYCLES=4, PERIOD_MIN=1, NUM_PERIODS=2, BUZZ_CYCLES=3, NUM_TEAMS=2, SCORE_DIGITS=2.)
- Reset, then start_stop -> state=1. After 4 cycles sec_bcd=0x59, min_bcd=0x00. After 60 ticks: state=3, clock 00:00, buzzer high exactly 3 cycles.
- In PERIOD_END, start_stop -> state=2, period=2, clock 01:00. Then start_stop and run 60 ticks -> state=4, buzzer 3 cycles. A further start_stop leaves state=4.
- Pause 2 cycles into a second, hold 10 cycles, then resume -> the next tick arrives 2 cycles after resume and the clock is unchanged during the pause.
- Team 1: +3 x33 -> 0x99 saturated. Then pts=0 -> 0x98. Team 0: pts=0 from 0 -> stays 0x00. team_sel=5 -> no change.
- Tick, start_stop and pts_valid(+2, team 0) in the same cycle -> time decremented, state=PAUSED, score 0x02.
- clear_game mid-RUNNING with buzzer active, and async reset mid-countdown -> all outputs at reset values on the next cycle (immediately for reset).

Source files
------------

// File: rtl/game_clock_scoreboard_if.sv
// Control pulses in, packed BCD display digits and game status out.
interface game_clock_scoreboard_if #(
    parameter int NUM_TEAMS    = 2,
    parameter int SCORE_DIGITS = 3
);
    logic                                clear_game;
    logic                                start_stop;
    logic                                pts_valid;
    logic [1:0]                          pts;
    logic [2:0]                          team_sel;
    logic [7:0]                          min_bcd;
    logic [7:0]                          sec_bcd;
    logic [3:0]                          period;
    logic [NUM_TEAMS*4*SCORE_DIGITS-1:0] score_bcd;
    logic [2:0]                          state;
    logic                                buzzer;

    modport master (output clear_game, start_stop, pts_valid, pts, team_sel,
                    input  min_bcd, sec_bcd, period, score_bcd, state, buzzer);
    modport slave  (input  clear_game, start_stop, pts_valid, pts, team_sel,
                    output min_bcd, sec_bcd, period, score_bcd, state, buzzer);
endinterface

// File: rtl/game_clock_scoreboard.sv
// Multi-period BCD countdown game clock with an N-team saturating BCD score bank.
module game_clock_scoreboard_lane #(
    parameter int SCORE_DIGITS = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        enable,
    input  logic [1:0]                  pts,
    output logic [4*SCORE_DIGITS-1:0]   score
);
    localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

    logic [4*SCORE_DIGITS-1:0] sum, diff;
    logic [4:0]                digit;
    logic                      carry, borrow;

    // Ripple BCD add and decrement; a carry out of the top digit means saturate.
    always_comb begin
        sum    = '0;
        diff   = '0;
        digit  = '0;
        carry  = 1'b0;
        borrow = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            digit = {1'b0, score[4*i +: 4]} + {4'b0, carry} + ((i == 0) ? {3'b0, pts} : 5'd0);
            carry = (digit > 5'd9);
            if (carry) digit = digit - 5'd10;
            sum[4*i +: 4] = digit[3:0];
            if (borrow && score[4*i +: 4] == 4'd0) begin
                diff[4*i +: 4] = 4'd9;
            end else begin
                diff[4*i +: 4] = score[4*i +: 4] - {3'b0, borrow};
                borrow = 1'b0;
            end
        end
        if (carry) sum = ALL_NINES;
        if (score == '0) diff = '0;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset)      score <= '0;
        else if (clear)  score <= '0;
        else if (enable) score <= (pts == 2'd0) ? diff : sum;
endmodule

module game_clock_scoreboard #(
    parameter int TICK_CYCLES  = 100000000,
    parameter int PERIOD_MIN   = 12,
    parameter int NUM_PERIODS  = 4,
    parameter int NUM_TEAMS    = 2,
    parameter int SCORE_DIGITS = 3,
    parameter int BUZZ_CYCLES  = 50000000
) (
    input logic                    clock,
    input logic                    reset,
    game_clock_scoreboard_if.slave bus
);
    localparam int              TW          = $clog2(TICK_CYCLES);
    localparam int              BW          = $clog2(BUZZ_CYCLES + 1);
    localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [BW-1:0]   BUZZ_LOAD   = BW'(BUZZ_CYCLES - 1);
    localparam logic [3:0]      LAST_PERIOD = 4'(NUM_PERIODS);
    localparam logic [7:0]      MIN_INIT    = 8'((PERIOD_MIN / 10) * 16 + PERIOD_MIN % 10);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUNNING    = 3'd1,
        PAUSED     = 3'd2,
        PERIOD_END = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    state_t          st;
    logic [7:0]      mins, secs, next_min, next_sec;
    logic [3:0]      per;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   buzz_cnt;
    logic            buzz, tick, at_zero, accept;

    assign tick    = (st == RUNNING) && (tick_cnt == TICK_LAST);
    assign at_zero = (next_min == 8'h00) && (next_sec == 8'h00);

    // One-second BCD decrement with borrow; holds at 00:00.
    always_comb begin
        next_sec = secs;
        next_min = mins;
        if (secs[3:0] != 4'd0) begin
            next_sec[3:0] = secs[3:0] - 4'd1;
        end else if (secs[7:4] != 4'd0) begin
            next_sec = {secs[7:4] - 4'd1, 4'd9};
        end else if (mins != 8'h00) begin
            next_sec = 8'h59;
            if (mins[3:0] != 4'd0) next_min[3:0] = mins[3:0] - 4'd1;
            else                   next_min = {mins[7:4] - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st <= IDLE; mins <= MIN_INIT; secs <= 8'h00; per <= 4'd1;
            tick_cnt <= '0; buzz_cnt <= '0; buzz <= 1'b0;
        end else if (bus.clear_game) begin
            st <= IDLE; mins <= MIN_INIT; secs <= 8'h00; per <= 4'd1;
            tick_cnt <= '0; buzz_cnt <= '0; buzz <= 1'b0;
        end else begin
            if (buzz) begin
                if (buzz_cnt == '0) buzz <= 1'b0;
                else                buzz_cnt <= buzz_cnt - 1'b1;
            end
            case (st)
                IDLE: if (bus.start_stop) st <= RUNNING;
                RUNNING: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        mins <= next_min;
                        secs <= next_sec;
                    end
                    // End of period outranks a coincident start_stop.
                    if (tick && at_zero) begin
                        st       <= (per < LAST_PERIOD) ? PERIOD_END : GAME_OVER;
                        buzz     <= 1'b1;
                        buzz_cnt <= BUZZ_LOAD;
                    end else if (bus.start_stop) begin
                        st <= PAUSED;
                    end
                end
                PAUSED: if (bus.start_stop) st <= RUNNING;
                PERIOD_END: if (bus.start_stop) begin
                    st <= PAUSED; per <= per + 4'd1;
                    mins <= MIN_INIT; secs <= 8'h00; tick_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign accept = bus.pts_valid && ({1'b0, bus.team_sel} < 4'(NUM_TEAMS)) &&
                    (st == RUNNING || st == PAUSED || st == PERIOD_END);

    logic [NUM_TEAMS-1:0][4*SCORE_DIGITS-1:0] scores;

    for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
        game_clock_scoreboard_lane #(.SCORE_DIGITS(SCORE_DIGITS)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .clear  (bus.clear_game),
            .enable (accept && (bus.team_sel == 3'(t))),
            .pts    (bus.pts),
            .score  (scores[t])
        );
    end

    assign bus.state     = st;
    assign bus.min_bcd   = mins;
    assign bus.sec_bcd   = secs;
    assign bus.period    = per;
    assign bus.buzzer    = buzz;
    assign bus.score_bcd = scores;
endmodule
